// File: rtl/uart_tx_arb_if.sv
// Handshake and serial-line bundle between two byte producers and the TX arbiter.
interface uart_tx_arb_if;
    logic [1:0] req;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [1:0] ack;
    logic       busy;
    logic       owner;
    logic       done_tick;
    logic       tx;

    modport master (output req, din0, din1, input ack, busy, owner, done_tick, tx);
    modport slave  (input req, din0, din1, output ack, busy, owner, done_tick, tx);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX line between two requesters; frames are
// start bit, DBIT data bits LSB first, and SB_TICK ticks of stop, counted on s_tick.
module uart_tx_arb #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tick,
    uart_tx_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state_q, state_d;
    logic [5:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [1:0] ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tx_q, tx_d;
    logic       gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b1;   // requester 0 wins the first contention
            owner_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        last_d  = last_q;
        owner_d = owner_q;
        ack_d   = 2'b00;
        done_d  = 1'b0;
        gnt     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    b_d     = gnt ? bus.din1 : bus.din0;
                    ack_d   = gnt ? 2'b10 : 2'b01;
                    owner_d = gnt;
                    last_d  = gnt;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 6'd15) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 6'd15) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == 3'(DBIT - 1)) state_d = STOP;
                        else                     n_d = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == 6'(SB_TICK - 1)) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so tx moves with the state edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.done_tick = done_q;
    assign bus.tx        = tx_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: default instance on a 1-in-4 s_tick, variant with s_tick tied high.
module tb_uart_tx_arb;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tdiv = 2'd0;
    logic       s_tick;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         ack0_cnt = 0, ack1_cnt = 0, done_cnt = 0;

    uart_tx_arb_if bus ();
    uart_tx_arb_if bus2 ();

    uart_tx_arb dut (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus));
    uart_tx_arb #(.DBIT(7), .SB_TICK(32)) dut2 (.clk(clk), .reset(reset), .s_tick(1'b1), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign s_tick = (tdiv == 2'd3);

    always @(negedge clk) begin
        if (bus.ack[0])    ack0_cnt <= ack0_cnt + 1;
        if (bus.ack[1])    ack1_cnt <= ack1_cnt + 1;
        if (bus.done_tick) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next negedge whose cycle carries an s_tick; a grant there starts on a tick boundary.
    task automatic align();
        @(negedge clk);
        while (tdiv != 2'd3) @(negedge clk);
    endtask

    // Waits for a start bit, then samples mid-bit by tick count until done_tick.
    task automatic rx_frame(input bit sel, input int dbit, output logic [7:0] data,
                            output int clks, output int ticks, output int waitc);
        logic tv;
        int   k;
        waitc = 0;
        data  = '0;
        clks  = 0;
        ticks = 0;
        while ((sel ? bus2.tx : bus.tx) !== 1'b0 && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 5000) begin
            chk("rx_start_timeout", 32'(waitc), 32'd0);
            return;
        end
        while ((sel ? bus2.done_tick : bus.done_tick) !== 1'b1 && clks < 3000) begin
            tv = sel ? bus2.tx : bus.tx;
            if (ticks >= 8 && ((ticks - 8) % 16) == 0) begin
                k = (ticks - 8) / 16;
                if (k == 0)                   chk("start_bit", 32'(tv), 32'd0);
                else if (k <= dbit)           data[k-1] = tv;
                else if (k == dbit + 1)       chk("stop_bit", 32'(tv), 32'd1);
            end
            if (sel || s_tick) ticks++;
            @(negedge clk);
            clks++;
        end
        if (clks >= 3000) chk("rx_done_timeout", 32'(clks), 32'd0);
    endtask

    logic [7:0] d;
    int c, t, w, a0, a1, dc;

    initial begin
        bus.req = 2'b00;  bus.din0 = 8'h00;  bus.din1 = 8'h00;
        bus2.req = 2'b00; bus2.din0 = 8'h00; bus2.din1 = 8'h00;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_done", 32'(bus.done_tick), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        reset = 1'b0;

        // single request, grant cycle aligned to a tick so every bit is 64 clk
        align();
        a0 = ack0_cnt;
        bus.din0 = 8'hA5; bus.req = 2'b01;
        @(negedge clk);
        chk("single_ack", 32'(bus.ack), 32'b01);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_tx_low", 32'(bus.tx), 32'd0);
        bus.req = 2'b00;
        rx_frame(1'b0, 8, d, c, t, w);
        chk("single_data", 32'(d), 32'hA5);
        chk("single_clks", 32'(c), 32'd640);
        chk("single_ticks", 32'(t), 32'd160);
        chk("single_owner", 32'(bus.owner), 32'd0);
        #1 chk("single_ack_width", 32'(ack0_cnt - a0), 32'd1);

        // late request: req[1] arrives mid-frame, granted right after done_tick
        align();
        bus.din0 = 8'h3C; bus.req = 2'b01;
        @(negedge clk);
        chk("late_ack0", 32'(bus.ack), 32'b01);
        bus.req = 2'b00;
        fork
            rx_frame(1'b0, 8, d, c, t, w);
            begin
                repeat (200) @(negedge clk);
                bus.din1 = 8'hC3; bus.req = 2'b10;
            end
        join
        chk("late_data0", 32'(d), 32'h3C);
        chk("late_done_ack", 32'(bus.ack), 32'b00);
        @(negedge clk);
        chk("late_ack1", 32'(bus.ack), 32'b10);
        chk("late_owner1", 32'(bus.owner), 32'd1);
        bus.req = 2'b00;
        rx_frame(1'b0, 8, d, c, t, w);
        chk("late_wait", 32'(w), 32'd0);
        chk("late_data1", 32'(d), 32'hC3);
        chk("late_ticks1", 32'(t), 32'd160);

        // contention with both held: alternating owners, 1 clk gaps
        align();
        bus.din0 = 8'h11; bus.din1 = 8'h22; bus.req = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_frame(1'b0, 8, d, c, t, w);
            chk($sformatf("cont%0d_owner", i), 32'(bus.owner), 32'(i % 2));
            chk($sformatf("cont%0d_data", i), 32'(d), (i % 2) ? 32'h22 : 32'h11);
            chk($sformatf("cont%0d_gap", i), 32'(w), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("cont%0d_ticks", i), 32'(t), 32'd160);
            if (i == 3) bus.req = 2'b00;
        end

        // one-clock req[0] pulse while busy must be ignored
        align();
        bus.din1 = 8'h5A; bus.req = 2'b10;
        @(negedge clk);
        chk("abort_ack1", 32'(bus.ack), 32'b10);
        bus.req = 2'b00;
        a0 = ack0_cnt;
        fork
            rx_frame(1'b0, 8, d, c, t, w);
            begin
                repeat (100) @(negedge clk);
                bus.din0 = 8'hEE; bus.req = 2'b01;
                @(negedge clk);
                bus.req = 2'b00;
            end
        join
        chk("abort_data1", 32'(d), 32'h5A);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_ack0", 32'(ack0_cnt - a0), 32'd0);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        chk("abort_idle_tx", 32'(bus.tx), 32'd1);

        // reset during data bit 3 of a requester-0 frame
        align();
        bus.din0 = 8'hF0; bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (280) @(negedge clk);
        chk("mid_bit3", 32'(bus.tx), 32'd0);
        dc = done_cnt;
        a1 = ack1_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(bus.tx), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        bus.din0 = 8'h96; bus.din1 = 8'h69; bus.req = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", 32'(bus.ack), 32'b01);
        chk("post_rst_owner", 32'(bus.owner), 32'd0);
        bus.req = 2'b00;
        #1;
        chk("mid_no_done", 32'(done_cnt - dc), 32'd0);
        chk("mid_no_ack1", 32'(ack1_cnt - a1), 32'd0);
        rx_frame(1'b0, 8, d, c, t, w);
        chk("post_rst_data", 32'(d), 32'h96);

        // variant: DBIT=7, SB_TICK=32, s_tick tied high
        @(negedge clk);
        bus2.din1 = 8'h7F; bus2.req = 2'b10;
        @(negedge clk);
        chk("var_ack", 32'(bus2.ack), 32'b10);
        chk("var_owner", 32'(bus2.owner), 32'd1);
        bus2.req = 2'b00;
        rx_frame(1'b1, 7, d, c, t, w);
        chk("var_data", 32'(d), 32'h7F);
        chk("var_clks", 32'(c), 32'd160);
        @(negedge clk);
        chk("var_idle_busy", 32'(bus2.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and transmit sequencer that shares a single UART serial line between two byte producers. It consumes the 16x oversampling enable pulse produced by the baud generator (`s_tick`), grants the line to one requester at a time, and serializes the granted byte as start bit, data bits (LSB first) and stop bit(s). It sits between the baud generator and the TX pin of the UART subsystem.

## Interface

Parameters:

- `DBIT`, 8: data bits per frame, legal range 5–8.
- `SB_TICK`, 16: stop-bit length in `s_tick` pulses. Legal values are 16, 24 and 32 (1, 1.5 and 2 stop bits).

Ports:

- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `s_tick`, input, 1: one-cycle enable pulse at 16x the baud rate, sourced from the baud generator.
- `req`, input, 2: `req[i]` high means requester i has a byte pending.
- `din0`, input, 8: byte for requester 0. Must be stable while `req[0]` is high.
- `din1`, input, 8: byte for requester 1. Must be stable while `req[1]` is high.
- `ack`, output, 2: one-cycle pulse on `ack[i]` when requester i's byte is latched.
- `busy`, output, 1: high from the grant cycle until the end of the stop bit.
- `owner`, output, 1: index of the current or most recent grantee.
- `done_tick`, output, 1: one-cycle pulse when the stop bit completes.
- `tx`, output, 1: serial line, idle high.

## Operation

- States are IDLE, START, DATA and STOP.
- Internal registers:
  - tick counter `s`, 6 bits.
  - bit counter `n`, 3 bits.
  - shift register `b`, 8 bits.
  - round-robin pointer `last`, 1 bit, holding the index of the last grantee.
- IDLE:
  - `tx` = 1 and `busy` = 0.
  - If exactly one `req` bit is high, grant that requester.
  - If both are high, grant `~last`.
  - On a grant, in the same cycle: latch the granted `din` into `b`, pulse `ack[i]`, set `owner` = i and `last` = i, clear `s` and `n`, and go to START.
- START:
  - `tx` = 0.
  - Each `s_tick` increments `s`.
  - On `s_tick` with `s` == 15: clear `s` and go to DATA.
- DATA:
  - `tx` = `b[0]`.
  - On `s_tick` with `s` == 15: shift `b` right and clear `s`.
  - If `n` == DBIT-1, go to STOP; otherwise increment `n`.
- STOP:
  - `tx` = 1.
  - On `s_tick` with `s` == SB_TICK-1: pulse `done_tick` and go to IDLE.
- `req` dropped before `ack` is legal. Nothing is latched and no frame is sent.
- `req[i]` held after `ack[i]` is treated as a new request at the next IDLE.
- With both requesters continuously requesting, frames alternate 0,1,0,1.
- Changes on `req` or `din*` while not in IDLE are ignored.

## Timing

- Reset values:
  - `tx` = 1, `busy` = 0, `ack` = 0, `done_tick` = 0, `owner` = 0.
  - `last` = 1, so requester 0 wins the first contention.
  - State = IDLE; `s`, `n` and `b` = 0.
- Reset asserted mid-frame forces `tx` high immediately (asynchronous). No `done_tick` is issued, and the aborted frame is not retried.
- Grant latency: `ack` is asserted in the first IDLE cycle in which `req` is seen high and registered.
- `tx` falls on the clock edge following the grant, independent of `s_tick`.
- An `s_tick` coinciding with the grant cycle is not counted.
- Bit durations:
  - The start bit and each data bit last exactly 16 `s_tick` pulses.
  - The stop bit lasts SB_TICK pulses.
  - Frame length is (1+DBIT)·16 + SB_TICK ticks.
- `done_tick`, the return to IDLE and `busy` falling all take effect on the same edge.
- The earliest next grant is the following cycle, giving a minimum inter-frame gap of 1 clk of idle-high `tx` after the stop bit.
- Outputs are registered: `tx`, `ack`, `busy`, `done_tick` and `owner` come from flops, with no combinational path from inputs.
- If `s_tick` is held high continuously, each clock counts as one tick. This case is legal and is used by the bench.

## Test plan

- **Single request.** Reset, then `s_tick` every 4 clk; `req`=01, `din0`=0xA5.
  - `ack`=01 for 1 clk and `busy`=1.
  - `tx` sequence, 64 clk per bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - `done_tick` occurs 640 clk after `tx` falls; `owner`=0.
- **Contention.**
  - `req`=11, `din0`=0x11, `din1`=0x22, both held high after `ack`.
  - Four consecutive frames carry owners 0,1,0,1 and bytes 0x11,0x22,0x11,0x22.
  - Each inter-frame gap is exactly 1 clk of `tx`=1 after the stop bit.
- **Late request.** `req[1]` rises mid-frame of requester 0 and `req[0]` is dropped after its `ack`. Requester 1 is granted in the cycle after `done_tick`.
- **Reset mid-frame.**
  - Assert `reset` during DATA bit 3: `tx`=1 and `busy`=0 immediately.
  - After release with `req`=11, requester 0 is granted first.
- **Parameter variant.** DBIT=7, SB_TICK=32, `s_tick` tied high, `din1`=0x7F.
  - Frame is 16 + 7·16 + 32 = 160 clk.
  - `done_tick` occurs at clk 160 after `tx` falls.
- **Aborted request.** `req[0]` pulses for 1 clk while busy. No `ack[0]` is issued and no frame is sent for requester 0.
